// File: rtl/rggen_apb_arbiter_pkg.sv
// rtl/rggen_apb_arbiter_pkg.sv - shared types and helpers for the APB arbiter
package rggen_apb_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } rggen_apb_arbiter_state_e;

    // Index/counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/rggen_round_robin_arbiter.sv
// rtl/rggen_round_robin_arbiter.sv - rotate-priority arbiter with last-grant pointer
module rggen_round_robin_arbiter
    import rggen_apb_arbiter_pkg::*;
#(
    parameter int REQUESTERS = 2,
    localparam int INDEX_WIDTH = clog2_min1(REQUESTERS)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [REQUESTERS-1:0]  i_request,
    input  logic                   i_update,
    output logic [REQUESTERS-1:0]  o_grant,
    output logic [INDEX_WIDTH-1:0] o_grant_index
);

    if (REQUESTERS == 1) begin : g_single
        logic unused_inputs;
        assign unused_inputs = ^{i_clk, i_rst, i_update};
        assign o_grant       = i_request;
        assign o_grant_index = '0;
    end else begin : g_multi
        logic [INDEX_WIDTH-1:0] last_grant_q;
        logic [INDEX_WIDTH-1:0] last_grant_d;

        // Search starts just after the last winner so it has lowest priority.
        always_comb begin
            logic [INDEX_WIDTH-1:0] idx;
            logic                   found;
            idx           = '0;
            found         = 1'b0;
            o_grant       = '0;
            o_grant_index = '0;
            for (int i = 1; i <= REQUESTERS; i++) begin
                idx = INDEX_WIDTH'((int'(last_grant_q) + i) % REQUESTERS);
                if (!found && i_request[idx]) begin
                    found          = 1'b1;
                    o_grant[idx]   = 1'b1;
                    o_grant_index  = idx;
                end
            end
        end

        // Pointer moves only when the grant is actually taken.
        always_comb begin
            last_grant_d = i_update ? o_grant_index : last_grant_q;
        end

        // Pointer register; resets so requester 0 wins first.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                last_grant_q <= INDEX_WIDTH'(REQUESTERS - 1);
            end else begin
                last_grant_q <= last_grant_d;
            end
        end
    end

endmodule

// File: rtl/rggen_apb_arbiter.sv
// rtl/rggen_apb_arbiter.sv - round-robin sharing of one APB slave port with watchdog
module rggen_apb_arbiter
    import rggen_apb_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 8,
    parameter int BUS_WIDTH      = 32,
    parameter int REQUESTERS     = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [REQUESTERS-1:0]    i_req_valid,
    input  logic [REQUESTERS-1:0]    i_req_write,
    input  logic [ADDRESS_WIDTH-1:0] i_req_address    [REQUESTERS],
    input  logic [BUS_WIDTH-1:0]     i_req_write_data [REQUESTERS],
    input  logic [BUS_WIDTH/8-1:0]   i_req_strobe     [REQUESTERS],
    output logic [REQUESTERS-1:0]    o_req_done,
    output logic [BUS_WIDTH-1:0]     o_req_read_data,
    output logic                     o_req_error,
    output logic                     o_psel,
    output logic                     o_penable,
    output logic                     o_pwrite,
    output logic [ADDRESS_WIDTH-1:0] o_paddr,
    output logic [BUS_WIDTH-1:0]     o_pwdata,
    output logic [BUS_WIDTH/8-1:0]   o_pstrb,
    input  logic                     i_pready,
    input  logic                     i_pslverr,
    input  logic [BUS_WIDTH-1:0]     i_prdata
);

    localparam int INDEX_WIDTH  = clog2_min1(REQUESTERS);
    localparam int STROBE_WIDTH = BUS_WIDTH / 8;
    localparam int COUNT_WIDTH  = clog2_min1(TIMEOUT_CYCLES + 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_LAST =
        COUNT_WIDTH'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    rggen_apb_arbiter_state_e state_q, state_d;
    logic [INDEX_WIDTH-1:0]   grant_index_q, grant_index_d;
    logic                     write_q, write_d;
    logic [ADDRESS_WIDTH-1:0] address_q, address_d;
    logic [BUS_WIDTH-1:0]     write_data_q, write_data_d;
    logic [STROBE_WIDTH-1:0]  strobe_q, strobe_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;
    logic [REQUESTERS-1:0]    done_q, done_d;
    logic [BUS_WIDTH-1:0]     read_data_q, read_data_d;
    logic                     error_q, error_d;

    logic [REQUESTERS-1:0]    grant;
    logic [INDEX_WIDTH-1:0]   grant_index;
    logic                     grant_update;
    logic                     timeout_hit;

    assign grant_update = (state_q == IDLE) && (|i_req_valid);
    assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (count_q == COUNT_LAST);

    rggen_round_robin_arbiter #(
        .REQUESTERS (REQUESTERS)
    ) u_arbiter (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_request     (i_req_valid),
        .i_update      (grant_update),
        .o_grant       (grant),
        .o_grant_index (grant_index)
    );

    // Transfer sequencing: capture winner in IDLE, then SETUP, then ACCESS until ready or abort.
    always_comb begin
        state_d       = state_q;
        grant_index_d = grant_index_q;
        write_d       = write_q;
        address_d     = address_q;
        write_data_d  = write_data_q;
        strobe_d      = strobe_q;
        count_d       = count_q;
        done_d        = '0;
        read_data_d   = '0;
        error_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (|i_req_valid) begin
                    grant_index_d = grant_index;
                    for (int i = 0; i < REQUESTERS; i++) begin
                        if (grant[i]) begin
                            write_d      = i_req_write[i];
                            address_d    = i_req_address[i];
                            write_data_d = i_req_write_data[i];
                            strobe_d     = i_req_strobe[i];
                        end
                    end
                    state_d = SETUP;
                end
            end
            SETUP: begin
                count_d = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (i_pready) begin
                    done_d[grant_index_q] = 1'b1;
                    read_data_d           = write_q ? '0 : i_prdata;
                    error_d               = i_pslverr;
                    state_d               = IDLE;
                end else if (timeout_hit) begin
                    done_d[grant_index_q] = 1'b1;
                    error_d               = 1'b1;
                    state_d               = IDLE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state, payload and response registers; async reset drops psel/penable at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= IDLE;
            grant_index_q <= '0;
            write_q       <= 1'b0;
            address_q     <= '0;
            write_data_q  <= '0;
            strobe_q      <= '0;
            count_q       <= '0;
            done_q        <= '0;
            read_data_q   <= '0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_index_q <= grant_index_d;
            write_q       <= write_d;
            address_q     <= address_d;
            write_data_q  <= write_data_d;
            strobe_q      <= strobe_d;
            count_q       <= count_d;
            done_q        <= done_d;
            read_data_q   <= read_data_d;
            error_q       <= error_d;
        end
    end

    assign o_psel          = (state_q != IDLE);
    assign o_penable       = (state_q == ACCESS);
    assign o_pwrite        = write_q;
    assign o_paddr         = address_q;
    assign o_pwdata        = write_data_q;
    assign o_pstrb         = strobe_q;
    assign o_req_done      = done_q;
    assign o_req_read_data = read_data_q;
    assign o_req_error     = error_q;

endmodule

// File: tb/tb_rggen_apb_arbiter.sv
// tb/tb_rggen_apb_arbiter.sv - bench for rggen_apb_arbiter
module tb_rggen_apb_arbiter;

    localparam int N  = 2;
    localparam int AW = 8;
    localparam int BW = 32;
    localparam int SW = 4;
    localparam int T  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]  req_valid, req_write;
    logic [AW-1:0] req_addr  [N];
    logic [BW-1:0] req_wdata [N];
    logic [SW-1:0] req_strb  [N];
    logic [N-1:0]  done;
    logic [BW-1:0] rdata;
    logic          err, psel, penable, pwrite, pready, pslverr;
    logic [AW-1:0] paddr;
    logic [BW-1:0] pwdata, prdata;
    logic [SW-1:0] pstrb;

    rggen_apb_arbiter #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .REQUESTERS(N), .TIMEOUT_CYCLES(T)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_write(req_write),
        .i_req_address(req_addr), .i_req_write_data(req_wdata), .i_req_strobe(req_strb),
        .o_req_done(done), .o_req_read_data(rdata), .o_req_error(err),
        .o_psel(psel), .o_penable(penable), .o_pwrite(pwrite), .o_paddr(paddr),
        .o_pwdata(pwdata), .o_pstrb(pstrb), .i_pready(pready), .i_pslverr(pslverr), .i_prdata(prdata)
    );

    // Second instance with the watchdog disabled.
    logic          rst0 = 1'b1;
    logic [N-1:0]  b_valid, b_write, b_done;
    logic [AW-1:0] b_addr  [N];
    logic [BW-1:0] b_wdata [N];
    logic [SW-1:0] b_strb  [N];
    logic [BW-1:0] b_rdata, b_pwdata, b_prdata;
    logic          b_err, b_psel, b_penable, b_pwrite, b_pready, b_pslverr;
    logic [AW-1:0] b_paddr;
    logic [SW-1:0] b_pstrb;
    bit            t0_finished = 1'b0;

    rggen_apb_arbiter #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .REQUESTERS(N), .TIMEOUT_CYCLES(0)) u_dut_t0 (
        .i_clk(clk), .i_rst(rst0), .i_req_valid(b_valid), .i_req_write(b_write),
        .i_req_address(b_addr), .i_req_write_data(b_wdata), .i_req_strobe(b_strb),
        .o_req_done(b_done), .o_req_read_data(b_rdata), .o_req_error(b_err),
        .o_psel(b_psel), .o_penable(b_penable), .o_pwrite(b_pwrite), .o_paddr(b_paddr),
        .o_pwdata(b_pwdata), .o_pstrb(b_pstrb), .i_pready(b_pready), .i_pslverr(b_pslverr), .i_prdata(b_prdata)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: a transfer is busy for one setup cycle plus access cycles.
    typedef struct {
        bit            busy;
        int            age;
        int            g;
        int            last;
        bit            wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] wdata;
        logic [SW-1:0] strb;
        logic [N-1:0]  done;
        logic [BW-1:0] rdata;
        bit            err;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.busy = 0; r.age = 0; r.g = 0; r.last = N - 1; r.wr = 0;
        r.addr = '0; r.wdata = '0; r.strb = '0; r.done = '0; r.rdata = '0; r.err = 0;
        return r;
    endfunction

    function automatic model_t model_next(model_t c);
        model_t n = c;
        bit found = 0;
        n.done = '0; n.rdata = '0; n.err = 0;
        if (!c.busy) begin
            for (int k = 1; k <= N; k++) begin
                int cand = (c.last + k) % N;
                if (!found && req_valid[cand]) begin
                    found = 1;
                    n.busy = 1; n.age = 0; n.g = cand; n.last = cand;
                    n.wr = req_write[cand]; n.addr = req_addr[cand];
                    n.wdata = req_wdata[cand]; n.strb = req_strb[cand];
                end
            end
        end else if (c.age == 0) begin
            n.age = 1;
        end else if (pready) begin
            n.done[c.g] = 1'b1;
            n.rdata = c.wr ? '0 : prdata;
            n.err = pslverr;
            n.busy = 0;
        end else if (T != 0 && c.age == T) begin
            n.done[c.g] = 1'b1;
            n.err = 1;
            n.busy = 0;
        end else begin
            n.age = c.age + 1;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= model_reset();
        else     m <= model_next(m);
    end

    always @(negedge clk) begin
        check("psel",    psel,    m.busy);
        check("penable", penable, m.busy && m.age >= 1);
        check("pwrite",  pwrite,  m.wr);
        check("paddr",   paddr,   m.addr);
        check("pwdata",  pwdata,  m.wdata);
        check("pstrb",   pstrb,   m.strb);
        check("done",    done,    m.done);
        check("rdata",   rdata,   m.rdata);
        check("error",   err,     m.err);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic new_payload(input int r);
        req_write[r] = 1'($urandom_range(0, 1));
        req_addr[r]  = AW'($urandom);
        req_wdata[r] = $urandom;
        req_strb[r]  = SW'($urandom);
    endtask

    task automatic xfer(input int r, input bit wr, input logic [AW-1:0] a, input logic [BW-1:0] wd,
                        input logic [SW-1:0] st, input int waits, input bit se, input logic [BW-1:0] rd,
                        output int lat, output int npsel, output int npen,
                        output logic [N-1:0] dv, output logic [BW-1:0] rv, output bit ev);
        int acc = 0;
        req_valid[r] = 1'b1; req_write[r] = wr; req_addr[r] = a; req_wdata[r] = wd; req_strb[r] = st;
        pready = 1'b0; pslverr = se; prdata = rd;
        lat = 0; npsel = 0; npen = 0; dv = '0; rv = '0; ev = 0;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (done != '0) begin
                lat = i; dv = done; rv = rdata; ev = err;
                req_valid[r] = 1'b0;
                break;
            end
            if (psel) begin
                npsel++;
                check("hold_paddr",  paddr,  a);
                check("hold_pwdata", pwdata, wd);
                check("hold_pstrb",  pstrb,  st);
                check("hold_pwrite", pwrite, wr);
                req_addr[r] = ~a; req_wdata[r] = ~wd; req_strb[r] = ~st;
            end
            if (psel && penable) begin
                npen++;
                acc++;
            end
            pready = (acc > waits);
        end
        if (lat == 0) check("xfer_done_within_bound", 0, 1);
        pready = 1'b0;
        pslverr = 1'b0;
    endtask

    // Watchdog-disabled instance: pready held low must never abort.
    initial begin
        bit seen = 0;
        b_valid = '0; b_write = '0; b_pready = 1'b0; b_pslverr = 1'b0; b_prdata = 32'h0000_1234;
        for (int r = 0; r < N; r++) begin b_addr[r] = '0; b_wdata[r] = '0; b_strb[r] = '0; end
        repeat (2) @(negedge clk);
        #1 rst0 = 1'b0;
        b_valid[0] = 1'b1; b_addr[0] = 8'h08;
        repeat (40) begin
            @(negedge clk); #1;
            if (b_done != '0) seen = 1;
        end
        check("t0_no_abort", seen, 0);
        check("t0_psel", b_psel, 1);
        check("t0_penable", b_penable, 1);
        b_pready = 1'b1;
        @(negedge clk); #1;
        b_valid[0] = 1'b0;
        check("t0_done", b_done, 2'b01);
        check("t0_rdata", b_rdata, 32'h0000_1234);
        t0_finished = 1'b1;
    end

    initial begin
        int lat, np, ne, k, cnt0, cnt1;
        logic [N-1:0]  dv;
        logic [BW-1:0] rv;
        bit ev;
        logic [AW-1:0] setup_addr;
        int stall = 0;

        req_valid = '0; req_write = '0; pready = 1'b0; pslverr = 1'b0; prdata = '0;
        for (int r = 0; r < N; r++) begin req_addr[r] = '0; req_wdata[r] = '0; req_strb[r] = '0; end
        setup_addr = '0;

        step();
        check("rst_psel", psel, 0);
        check("rst_done", done, 0);
        check("rst_paddr", paddr, 0);
        check("rst_rdata", rdata, 0);
        step();
        rst = 1'b0;

        xfer(0, 0, 8'h04, 32'h0, 4'h0, 0, 0, 32'h0000_0a05, lat, np, ne, dv, rv, ev);
        check("read_latency", lat, 3);
        check("read_psel_cycles", np, 2);
        check("read_penable_cycles", ne, 1);
        check("read_done", dv, 2'b01);
        check("read_data", rv, 32'h0000_0a05);
        check("read_error", ev, 0);

        xfer(1, 1, 8'h18, 32'h1, 4'b0001, 3, 0, 32'hffff_ffff, lat, np, ne, dv, rv, ev);
        check("write_latency", lat, 6);
        check("write_penable_cycles", ne, 4);
        check("write_done", dv, 2'b10);
        check("write_rdata_zero", rv, 0);

        xfer(0, 0, 8'h0c, 32'h0, 4'h0, 1, 1, 32'h5555_aaaa, lat, np, ne, dv, rv, ev);
        check("slverr_done", dv, 2'b01);
        check("slverr_error", ev, 1);
        step();
        check("slverr_error_cleared", err, 0);
        check("slverr_done_cleared", done, 0);

        xfer(1, 0, 8'h20, 32'h0, 4'h0, 1000, 0, 32'hdead_beef, lat, np, ne, dv, rv, ev);
        check("timeout_latency", lat, 18);
        check("timeout_access_cycles", ne, 16);
        check("timeout_done", dv, 2'b10);
        check("timeout_error", ev, 1);
        check("timeout_rdata", rv, 0);
        xfer(0, 0, 8'h24, 32'h0, 4'h0, 0, 0, 32'h0000_0077, lat, np, ne, dv, rv, ev);
        check("after_timeout_latency", lat, 3);
        check("after_timeout_rdata", rv, 32'h0000_0077);

        do_reset();
        req_write = '0; req_addr[0] = 8'h10; req_addr[1] = 8'h20;
        req_valid = 2'b11; pready = 1'b1; prdata = 32'h0000_00c3;
        k = 0; cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 200 && k < 8; i++) begin
            step();
            if (psel && !penable) setup_addr = paddr;
            if (done != '0) begin
                check("rr_order", done, (k % 2 == 0) ? 2'b01 : 2'b10);
                check("rr_addr", setup_addr, done[1] ? 8'h20 : 8'h10);
                if (done[0]) begin cnt0++; if (cnt0 == 4) req_valid[0] = 1'b0; end
                if (done[1]) begin cnt1++; if (cnt1 == 4) req_valid[1] = 1'b0; end
                k++;
            end
        end
        check("rr_count0", cnt0, 4);
        check("rr_count1", cnt1, 4);
        pready = 1'b0;

        do_reset();
        req_addr[0] = 8'h30; req_addr[1] = 8'h34; req_valid = 2'b11;
        step();
        step();
        check("pre_rst_penable", penable, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_psel", psel, 0);
        check("async_rst_penable", penable, 0);
        step();
        check("rst_no_done", done, 0);
        rst = 1'b0;
        pready = 1'b1;
        k = 0;
        for (int i = 0; i < 50 && k < 2; i++) begin
            step();
            if (done != '0) begin
                check("post_rst_order", done, (k == 0) ? 2'b01 : 2'b10);
                req_valid = req_valid & ~done;
                k++;
            end
        end
        check("post_rst_served", k, 2);

        for (int cyc = 0; cyc < 1500; cyc++) begin
            step();
            for (int r = 0; r < N; r++) begin
                if (req_valid[r] && done[r]) begin
                    if ($urandom_range(0, 3) == 0) new_payload(r);
                    else req_valid[r] = 1'b0;
                end else if (!req_valid[r]) begin
                    if ($urandom_range(0, 2) == 0) begin new_payload(r); req_valid[r] = 1'b1; end
                end else begin
                    if ($urandom_range(0, 15) == 0) req_valid[r] = 1'b0;
                    else if ($urandom_range(0, 7) == 0) new_payload(r);
                end
            end
            if (stall > 0) begin
                pready = 1'b0;
                stall--;
            end else begin
                pready = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 99) == 0) stall = 20;
            end
            pslverr = ($urandom_range(0, 7) == 0);
            prdata  = $urandom;
        end

        for (int i = 0; i < 1000 && !t0_finished; i++) step();
        check("t0_finished", t0_finished, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
